// File: rtl/obi_ssram_slave.sv
// OBI-facing word-addressed SSRAM model, responses in order LATENCY cycles after acceptance.
// Grants while fewer than MAX_OUT are outstanding; valid is a fire-and-forget pulse with no backpressure.
module obi_ssram_slave #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2,
   parameter int MAX_OUT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        proc_req,
   input  logic [31:0] addr,
   input  logic        web,
   input  logic [31:0] wdata,
   output logic        rdy,
   output logic [31:0] rdata,
   output logic        valid
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

   logic [31:0]        mem [DEPTH];
   logic [AW-1:0]      idx;
   logic               acc;
   logic [31:0]        rd_word;
   logic [LATENCY-1:0] pipe_vld;
   logic [31:0]        pipe_dat [LATENCY];
   logic [CW-1:0]      cnt;
   logic               unused_addr_bits;

   assign idx              = addr[AW+1:2];
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
   assign acc              = proc_req && rdy;

   // A response leaving this cycle frees its slot for a request accepted on the same edge.
   assign rdy   = !rst && ((cnt < CNT_MAX) || valid);
   assign valid = pipe_vld[LATENCY-1];
   assign rdata = pipe_dat[LATENCY-1];

   // Write responses carry zero data; reads capture the word on the acceptance edge.
   assign rd_word = (acc && web) ? mem[idx] : '0;

   always_ff @(posedge clk) begin
      if (acc && !web) begin
         mem[idx] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_dat[i] <= '0;
         end
         cnt <= '0;
      end else begin
         pipe_vld[0] <= acc;
         pipe_dat[0] <= rd_word;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
         end
         if (acc && !valid) begin
            cnt <= cnt + 1'b1;
         end else if (!acc && valid) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_MAX);

endmodule

// File: tb/tb_obi_ssram_slave.sv
// Scoreboard bench: three instances (L2/M2, L4/M2, L3/M3) checked for data, response cycle and grant pattern.
module tb_obi_ssram_slave;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  proc_req;
   logic [2:0]  web;
   logic [2:0]  rdy;
   logic [2:0]  valid;
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];

   logic [31:0] model [3][1024];
   exp_t        q0[$], q1[$], q2[$];
   int          cyc    = 0;
   int          n_chk  = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   obi_ssram_slave #(.DEPTH(1024), .LATENCY(2), .MAX_OUT(2)) u0 (
      .clk(clk), .rst(rst[0]), .proc_req(proc_req[0]), .addr(addr[0]), .web(web[0]),
      .wdata(wdata[0]), .rdy(rdy[0]), .rdata(rdata[0]), .valid(valid[0]));
   obi_ssram_slave #(.DEPTH(1024), .LATENCY(4), .MAX_OUT(2)) u1 (
      .clk(clk), .rst(rst[1]), .proc_req(proc_req[1]), .addr(addr[1]), .web(web[1]),
      .wdata(wdata[1]), .rdy(rdy[1]), .rdata(rdata[1]), .valid(valid[1]));
   obi_ssram_slave #(.DEPTH(1024), .LATENCY(3), .MAX_OUT(3)) u2 (
      .clk(clk), .rst(rst[2]), .proc_req(proc_req[2]), .addr(addr[2]), .web(web[2]),
      .wdata(wdata[2]), .rdy(rdy[2]), .rdata(rdata[2]), .valid(valid[2]));

   function automatic int lat(int k);
      case (k)
         0:       return 2;
         1:       return 4;
         default: return 3;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic push(int k, logic [31:0] d);
      exp_t e;
      e.d = d;
      e.c = cyc + lat(k);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic mon(int k);
      exp_t e;
      bit   have = 1'b0;
      case (k)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         chk($sformatf("unexpected_valid_u%0d", k), 32'd1, 32'd0);
      end else begin
         chk($sformatf("rdata_u%0d", k), rdata[k], e.d);
         chk($sformatf("resp_cycle_u%0d", k), cyc, e.c);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (valid[k] === 1'b1) mon(k);
      end
   end

   // Called at a negedge; holds the request until granted, returns at the negedge after acceptance.
   task automatic xfer(int k, logic we_n, logic [31:0] a, logic [31:0] d);
      int w = 0;
      proc_req[k] = 1'b1;
      web[k]      = we_n;
      addr[k]     = a;
      wdata[k]    = d;
      while (rdy[k] !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) begin
         chk($sformatf("grant_timeout_u%0d", k), 32'd1, 32'd0);
      end else if (we_n) begin
         push(k, model[k][a[11:2]]);
      end else begin
         push(k, 32'd0);
         model[k][a[11:2]] = d;
      end
      @(negedge clk);
      proc_req[k] = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int j;
      rst      = 3'b111;
      proc_req = 3'b000;
      web      = 3'b111;
      for (int k = 0; k < 3; k++) begin
         addr[k]  = '0;
         wdata[k] = '0;
      end
      idle(2);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_rdy_u%0d", k), rdy[k], 1'b0);
         chk($sformatf("reset_valid_u%0d", k), valid[k], 1'b0);
         chk($sformatf("reset_rdata_u%0d", k), rdata[k], 32'd0);
      end
      rst = 3'b000;
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("rdy_after_reset_u%0d", k), rdy[k], 1'b1);
      @(negedge clk);

      // Single write then read
      xfer(0, 1'b0, 32'h10, 32'hCAFEF00D);
      xfer(0, 1'b1, 32'h10, 32'h0);
      idle(4);

      // Back-to-back reads of preloaded words
      for (int i = 0; i < 8; i++) xfer(0, 1'b0, 32'(i * 4), 32'h100 + 32'(i));
      idle(4);
      for (int i = 0; i < 8; i++) begin
         chk("b2b_rdy", rdy[0], 1'b1);
         xfer(0, 1'b1, 32'(i * 4), 32'h0);
      end
      idle(4);

      // Outstanding limit: grant pattern 1,1,0,0 repeating
      for (int i = 0; i < 12; i++) xfer(1, 1'b0, 32'(i * 4), 32'hA000 + 32'(i));
      idle(8);
      j = 0;
      for (int i = 0; i < 12; i++) begin
         proc_req[1] = 1'b1;
         web[1]      = 1'b1;
         addr[1]     = 32'(j * 4);
         chk($sformatf("limit_rdy_c%0d", i), rdy[1], ((i % 4) < 2) ? 1'b1 : 1'b0);
         if (rdy[1] === 1'b1) begin
            push(1, model[1][j]);
            j++;
         end
         @(negedge clk);
      end
      proc_req[1] = 1'b0;
      idle(8);

      // Read-after-write with address wrap and ignored low bits
      xfer(0, 1'b0, 32'h0000_0004, 32'h5A5A5A5A);
      xfer(0, 1'b1, 32'h0000_1004, 32'h0);
      xfer(0, 1'b1, 32'h0000_0007, 32'h0);
      idle(4);

      // Reset while responses are in flight
      xfer(2, 1'b0, 32'd12, 32'h11111111);
      xfer(2, 1'b1, 32'd12, 32'h0);
      rst[2] = 1'b1;
      q2.delete();
      @(negedge clk);
      chk("midrst_rdy", rdy[2], 1'b0);
      chk("midrst_valid", valid[2], 1'b0);
      rst[2] = 1'b0;
      #1;
      chk("midrst_rdy_after", rdy[2], 1'b1);
      @(negedge clk);
      idle(6);
      xfer(2, 1'b1, 32'd12, 32'h0);
      idle(6);

      // Idle with junk on the inputs must leave memory untouched
      for (int i = 0; i < 10; i++) begin
         web[0]   = 1'b0;
         addr[0]  = $urandom;
         wdata[0] = $urandom;
         @(negedge clk);
      end
      web[0] = 1'b1;
      for (int i = 0; i < 8; i++) xfer(0, 1'b1, 32'(i * 4), 32'h0);

      idle(20);
      chk("drain_u0", q0.size(), 32'd0);
      chk("drain_u1", q1.size(), 32'd0);
      chk("drain_u2", q2.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/obi_ssram_slave.md
Name: obi_ssram_slave

Overview:
- Memory-side OBI responder that sits directly downstream of the fetch/load-store interface.
- Consumes the request, address, write-enable and write-data outputs of the interface.
- Returns rdy, rdata and valid to it.
- Models a synchronous word-addressed SRAM with configurable response latency and a bounded number of outstanding transactions. One instance is used as IRAM and one as DRAM.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 2, cycles from acceptance edge to valid pulse; legal range 1 to 8.
- MAX_OUT, 2, maximum accepted-but-unanswered transactions; legal range 1 to LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- proc_req  in  1  transaction request from the interface.
- addr  in  32  byte address; word index = addr[log2(DEPTH)+1:2].
- web  in  1  write enable, active low (0 = write, 1 = read).
- wdata  in  32  write data.
- rdy  out  1  grant; a transaction is accepted in a cycle where proc_req=1 and rdy=1.
- rdata  out  32  read data, meaningful only while valid=1.
- valid  out  1  one-cycle response pulse per accepted transaction.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values:
  - While rst=1: rdy=0, valid=0, rdata=0, outstanding counter=0, latency pipeline cleared.
  - First cycle after reset release: rdy=1.
  - Memory array contents are not reset.
- Acceptance: on the rising edge where proc_req=1 and rdy=1, the request is accepted.
  - Write (web=0): mem[index] <= wdata on that same edge.
  - Read (web=1): mem[index] is sampled on that same edge.
- Address rules:
  - addr[1:0] is ignored.
  - Address bits above the index are ignored, so the address wraps modulo DEPTH words.
- Latency pipeline: LATENCY stages, each holding {vld, data}.
  - The accepted entry enters stage 1.
  - valid/rdata are driven from stage LATENCY.
  - Response for a transaction accepted at edge t is visible in the cycle following edge t+LATENCY-1; i.e. LATENCY=1 gives valid in the cycle right after acceptance.
  - Responses are returned in order, one per cycle maximum.
- Write responses: valid is pulsed as well, with rdata=0.
- Outstanding counter cnt, width ceil(log2(MAX_OUT+1)):
  - +1 on acceptance only; -1 on valid only; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUT and never underflows.
- Grant rule: rdy = !rst && ((cnt < MAX_OUT) || valid). The slot freed by a response leaving this cycle may be reused in the same cycle.
  - With MAX_OUT = LATENCY, a back-to-back request stream sees rdy held high: one transaction per cycle.
  - With MAX_OUT < LATENCY, rdy drops once cnt = MAX_OUT and no response is leaving.
- No response back-pressure: valid is never held; the consumer must take it in the pulse cycle.
- Ordering and hazards:
  - A read accepted after a write to the same word returns the written data, even if the write response is still in flight.
  - One acceptance per cycle, so there is no same-cycle read/write conflict.
- Idle behaviour:
  - proc_req=0 leaves memory and cnt unchanged.
  - Inputs are don't-care while proc_req=0 or rdy=0.
- Reset mid-operation:
  - In-flight responses are discarded; no valid after release.
  - Writes already accepted remain in memory.
  - cnt returns to 0.

Test Plan:
- Reset then single write/read (LATENCY=2, MAX_OUT=2): write addr=0x10 data=0xCAFEF00D accepted at edge 0 -> valid=1, rdata=0 in cycle after edge 1. Read addr=0x10 -> valid with rdata=0xCAFEF00D two cycles after its accept.
- Back-to-back reads (LATENCY=2, MAX_OUT=2): reads of words 0..7 on 8 consecutive cycles, preloaded 0x100+i -> rdy stays 1. Valid high for 8 consecutive cycles with rdata 0x100..0x107 in order, starting 2 cycles after the first accept.
- Outstanding limit (LATENCY=4, MAX_OUT=2): continuous requests -> rdy=1, 1, then 0 for two cycles, then 1 when the first valid appears. Steady state: 2 acceptances per 4 cycles; cnt never exceeds 2.
- Read-after-write and wrap (DEPTH=1024): write 0x5A5A5A5A to addr=0x0000_0004, then read addr=0x0000_1004 on the next cycle -> rdata=0x5A5A5A5A. Read addr=0x0000_0007 -> same data (low bits ignored).
- Reset mid-flight (LATENCY=3): accept write 0x11111111 to word 3, then a read of word 3, then assert rst for 1 cycle before any valid -> no valid after release, rdy=1 in the first post-reset cycle. A new read of word 3 returns 0x11111111.
- Idle/stall: proc_req=0 for 10 cycles with random addr/wdata/web=0 -> no valid, memory unchanged (verified by readback), cnt=0.
